// File: rtl/button_deb_pkg.sv
// Shared FSM encodings and cycle-count helpers for the button debouncer array.
package button_deb_pkg;

    localparam logic ST_STABLE = 1'b0;
    localparam logic ST_VERIFY = 1'b1;

    function automatic int unsigned cycles_for(input int unsigned khz, input int unsigned ms);
        return khz * ms;
    endfunction

    // Wide enough to hold the terminal count itself, so counters never wrap.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_deb_chan.sv
// One debounce channel: 2-flop synchronizer, STABLE/VERIFY qualifier, edge pulses, toggle.
// Hold counter and long_o pulse exist only with BUTTON_DEB_ARRAY_LONGPRESS_EN defined.
module button_deb_chan
    import button_deb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 4
`ifdef BUTTON_DEB_ARRAY_LONGPRESS_EN
    ,
    parameter int unsigned LONG_CYCLES = 10
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o,
    output logic long_o
);

    localparam int unsigned CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          tog_q, tog_d;
    logic          commit;

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        commit  = 1'b0;
        tog_d   = tog_q ^ press_q;
        if (state_q == ST_STABLE) begin
            if (s != level_q) begin
                if (DEB_CYCLES <= 1) begin
                    commit = 1'b1;
                end else begin
                    state_d = ST_VERIFY;
                    cnt_d   = CW'(1);
                end
            end
        end else begin
            // Any return to the old level mid-count is a glitch: drop it silently.
            if (s == level_q) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end else if (cnt_q >= DEB_LAST) begin
                commit = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (commit) begin
            level_d = ~level_q;
            press_d = ~level_q;
            rel_d   = level_q;
            state_d = ST_STABLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tog_q   <= tog_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign toggle_o  = tog_q;

`ifdef BUTTON_DEB_ARRAY_LONGPRESS_EN
    localparam int unsigned HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating at LONG_MAX is what limits the pulse to once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (level_q && hold_q != LONG_MAX) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_d == LONG_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_deb_array.sv
// NCHAN independent debounced buttons with press/release pulses and toggle state.
// Define BUTTON_DEB_ARRAY_LONGPRESS_EN to add the per-channel long-press detector.
module button_deb_array
    import button_deb_pkg::*;
#(
    parameter int unsigned NCHAN       = 4,
    parameter int unsigned CLK_FREQ    = 95000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] button_in,
    output logic [NCHAN-1:0] button_level,
    output logic [NCHAN-1:0] press_pulse,
    output logic [NCHAN-1:0] release_pulse,
    output logic [NCHAN-1:0] toggle_state,
    output logic [NCHAN-1:0] long_press
);

    localparam int unsigned DEB_CYCLES  = cycles_for(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = cycles_for(CLK_FREQ, LONG_MS);

    if (NCHAN < 1 || NCHAN > 32 || DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
        $error("button_deb_array: illegal parameter set");
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        button_deb_chan #(
            .DEB_CYCLES (DEB_CYCLES)
`ifdef BUTTON_DEB_ARRAY_LONGPRESS_EN
            ,
            .LONG_CYCLES(LONG_CYCLES)
`endif
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (button_in[i]),
            .level_o  (button_level[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .toggle_o (toggle_state[i]),
            .long_o   (long_press[i])
        );
    end

endmodule

// File: tb/tb_button_deb_array.sv
// Directed bench for button_deb_array with DEB_CYCLES=4, LONG_CYCLES=10.
module tb_button_deb_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] button_in = '0;
    logic [3:0] button_level, press_pulse, release_pulse, toggle_state, long_press;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BUTTON_DEB_ARRAY_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    button_deb_array #(
        .NCHAN(4), .CLK_FREQ(1), .DEBOUNCE_MS(4), .LONG_MS(10)
    ) dut (
        .clk(clk), .rst(rst), .button_in(button_in),
        .button_level(button_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .toggle_state(toggle_state),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        #1 rst = 1'b1;
        tick(); tick();
        e = '0;
        n_checks += 4;
        if (button_level !== e) begin n_fail++; $display("FAIL reset_level: got %b want %b", button_level, e); end
        if (press_pulse !== e) begin n_fail++; $display("FAIL reset_press: got %b want %b", press_pulse, e); end
        if (release_pulse !== e) begin n_fail++; $display("FAIL reset_release: got %b want %b", release_pulse, e); end
        if (toggle_state !== e || long_press !== e) begin
            n_fail++; $display("FAIL reset_toggle_long: got %b/%b want %b", toggle_state, long_press, e);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_press();
        logic [3:0] ep, el, et;
        button_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ep = (k == 6) ? 4'b0001 : 4'b0000;
            el = (k >= 6) ? 4'b0001 : 4'b0000;
            et = (k >= 7) ? 4'b0001 : 4'b0000;
            n_checks += 3;
            if (press_pulse !== ep) begin n_fail++; $display("FAIL press_pulse k=%0d: got %b want %b", k, press_pulse, ep); end
            if (button_level !== el) begin n_fail++; $display("FAIL press_level k=%0d: got %b want %b", k, button_level, el); end
            if (toggle_state !== et) begin n_fail++; $display("FAIL press_toggle k=%0d: got %b want %b", k, toggle_state, et); end
        end
        button_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ep = (k == 6) ? 4'b0001 : 4'b0000;
            el = (k < 6) ? 4'b0001 : 4'b0000;
            n_checks += 3;
            if (release_pulse !== ep) begin n_fail++; $display("FAIL release_pulse k=%0d: got %b want %b", k, release_pulse, ep); end
            if (button_level !== el) begin n_fail++; $display("FAIL release_level k=%0d: got %b want %b", k, button_level, el); end
            if (toggle_state !== 4'b0001) begin n_fail++; $display("FAIL release_toggle k=%0d: got %b want 0001", k, toggle_state); end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] ep, er, el;
        button_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks += 2;
            if (press_pulse !== 4'b0 || release_pulse !== 4'b0) begin
                n_fail++; $display("FAIL glitch_pulse k=%0d: got %b/%b want 0000", k, press_pulse, release_pulse);
            end
            if (button_level !== 4'b0 || toggle_state !== 4'b0001) begin
                n_fail++; $display("FAIL glitch_state k=%0d: got %b/%b want 0000/0001", k, button_level, toggle_state);
            end
            if (k == 3) button_in[1] = 1'b0;
        end
        button_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ep = (k == 6) ? 4'b0010 : 4'b0000;
            er = (k == 10) ? 4'b0010 : 4'b0000;
            el = (k >= 6 && k < 10) ? 4'b0010 : 4'b0000;
            n_checks += 3;
            if (press_pulse !== ep) begin n_fail++; $display("FAIL min_press k=%0d: got %b want %b", k, press_pulse, ep); end
            if (release_pulse !== er) begin n_fail++; $display("FAIL min_release k=%0d: got %b want %b", k, release_pulse, er); end
            if (button_level !== el) begin n_fail++; $display("FAIL min_level k=%0d: got %b want %b", k, button_level, el); end
            if (k == 4) button_in[1] = 1'b0;
        end
        n_checks++;
        if (toggle_state !== 4'b0011) begin n_fail++; $display("FAIL min_toggle: got %b want 0011", toggle_state); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e;
        button_in = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = (k == 6) ? 4'b1001 : 4'b0000;
            n_checks++;
            if (press_pulse !== e) begin n_fail++; $display("FAIL simul_press k=%0d: got %b want %b", k, press_pulse, e); end
        end
        n_checks++;
        if (toggle_state !== 4'b1010) begin n_fail++; $display("FAIL simul_toggle: got %b want 1010", toggle_state); end
        button_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = (k == 6) ? 4'b1001 : 4'b0000;
            n_checks++;
            if (release_pulse !== e) begin n_fail++; $display("FAIL simul_release k=%0d: got %b want %b", k, release_pulse, e); end
        end
    endtask

    task automatic test_reset_in_verify();
        logic [3:0] ep, et;
        button_in[2] = 1'b1;
        repeat (4) tick();
        #1 rst = 1'b1;
        #1;
        n_checks += 2;
        if (toggle_state !== 4'b0 || button_level !== 4'b0) begin
            n_fail++; $display("FAIL rstv_state: got %b/%b want 0000/0000", toggle_state, button_level);
        end
        if (press_pulse !== 4'b0 || release_pulse !== 4'b0 || long_press !== 4'b0) begin
            n_fail++; $display("FAIL rstv_pulses: got %b/%b/%b want 0", press_pulse, release_pulse, long_press);
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ep = (k == 6) ? 4'b0100 : 4'b0000;
            et = (k >= 7) ? 4'b0100 : 4'b0000;
            n_checks += 2;
            if (press_pulse !== ep) begin n_fail++; $display("FAIL rstv_press k=%0d: got %b want %b", k, press_pulse, ep); end
            if (toggle_state !== et) begin n_fail++; $display("FAIL rstv_toggle k=%0d: got %b want %b", k, toggle_state, et); end
        end
        button_in[2] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_long_press();
        logic [3:0] e;
        button_in[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            e = (LP_EN && k == 16) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (long_press !== e) begin n_fail++; $display("FAIL long_hold k=%0d: got %b want %b", k, long_press, e); end
            if (k == 6) begin
                n_checks++;
                if (press_pulse !== 4'b0001) begin n_fail++; $display("FAIL long_anchor: got %b want 0001", press_pulse); end
            end
            if (k == 20) button_in[0] = 1'b0;
        end
        button_in[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            n_checks++;
            if (long_press !== 4'b0) begin n_fail++; $display("FAIL long_short k=%0d: got %b want 0000", k, long_press); end
            if (k == 8) button_in[0] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_simultaneous();
        test_reset_in_verify();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
